controller_mc: RTL and testbench

Multi-channel, queued successor of the single-task MVU controller. It holds one independent countdown engine per channel. Each engine accepts task lengths into a small per-channel job queue and runs them back to back with per-channel stall. It reports completion through a one-cycle done pulse and a sticky, maskable interrupt to the embedded CPU. It sits between the CPU register file and the MVU datapath; a countdown of 0 completes immediately and never hangs.

---
 rtl/controller_pkg.sv | 22 ++
 rtl/controller_chan.sv | 164 ++++++++++++++++
 rtl/controller_mc.sv | 68 ++++++
 tb/tb_controller_mc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// ============================================================================
// Module      : controller_pkg
// Description : Shared state type and default sizing for the multi-channel
//               countdown controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam int BCNTDWN_DEF = 29;
    localparam int QDEPTH_DEF  = 2;

endpackage

`default_nettype wire

// File: rtl/controller_chan.sv
// ============================================================================
// Module      : controller_chan
// Description : One countdown engine: job queue, FSM, counter and sticky flags.
//               The abort port is present only with CONTROLLER_ABORT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module controller_chan
    import controller_pkg::*;
#(
    parameter int BCNTDWN = BCNTDWN_DEF,
    parameter int QDEPTH  = QDEPTH_DEF
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [BCNTDWN-1:0] countdown,
    input  logic               step,
    input  logic               irq_ack,
`ifdef CONTROLLER_ABORT_EN
    input  logic               abort,
`endif
    output logic               full,
    output logic               run,
    output logic               done,
    output logic               irq_pend,
    output logic               ovf
);

    localparam int c_pw = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_cw = $clog2(QDEPTH + 1);

    logic [BCNTDWN-1:0] r_mem [QDEPTH];
    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    ctrl_state_t        r_state;
    logic [BCNTDWN-1:0] r_counter;

    logic               w_kill;
    logic               w_empty;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_finish;
    logic               w_set_pend;
    logic [BCNTDWN-1:0] w_head;

`ifdef CONTROLLER_ABORT_EN
    assign w_kill = abort;
`else
    assign w_kill = 1'b0;
`endif

    function automatic logic [c_pw-1:0] ptr_next(input logic [c_pw-1:0] p);
        return (p == c_pw'(QDEPTH - 1)) ? '0 : p + c_pw'(1);
    endfunction

    // full comes from the registered occupancy, so a same-cycle pop never frees a slot for a push
    assign full       = (r_count == c_cw'(QDEPTH));
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_push     = start & ~full & ~w_kill;
    assign w_drop     = start & full & ~w_kill;
    assign w_pop      = ~w_empty & ~w_kill & ((r_state == IDLE) | (r_state == DONE));
    assign w_finish   = (r_state == RUN) & ~w_kill & step & (r_counter == BCNTDWN'(1));
    assign w_set_pend = w_finish | (w_pop & (w_head == '0));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= countdown;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_kill) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= IDLE;
            r_counter <= '0;
            run       <= 1'b0;
            done      <= 1'b0;
            irq_pend  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_pop) begin
                        // zero-length jobs complete without ever entering RUN
                        if (w_head == '0) begin
                            r_state   <= DONE;
                            r_counter <= '0;
                            run       <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_state   <= RUN;
                            r_counter <= w_head;
                            run       <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                        run     <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_kill) begin
                        r_state   <= IDLE;
                        r_counter <= '0;
                        run       <= 1'b0;
                    end else if (step) begin
                        if (r_counter == BCNTDWN'(1)) begin
                            r_state   <= DONE;
                            r_counter <= '0;
                            run       <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_counter <= r_counter - BCNTDWN'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_counter <= '0;
                    run       <= 1'b0;
                end
            endcase

            if (w_set_pend) begin
                irq_pend <= 1'b1;
            end else if (irq_ack) begin
                irq_pend <= 1'b0;
            end

            if (w_drop) begin
                ovf <= 1'b1;
            end else if (irq_ack) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/controller_mc.sv
// ============================================================================
// Module      : controller_mc
// Description : NCHAN independent queued countdown engines with a shared,
//               maskable interrupt. Optional abort via CONTROLLER_ABORT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module controller_mc
    import controller_pkg::*;
#(
    parameter int NCHAN   = 4,
    parameter int BCNTDWN = BCNTDWN_DEF,
    parameter int QDEPTH  = QDEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [NCHAN-1:0]         start,
    input  logic [NCHAN*BCNTDWN-1:0] countdown,
    input  logic [NCHAN-1:0]         step,
    input  logic [NCHAN-1:0]         irq_mask,
    input  logic [NCHAN-1:0]         irq_ack,
`ifdef CONTROLLER_ABORT_EN
    input  logic [NCHAN-1:0]         abort,
`endif
    output logic [NCHAN-1:0]         full,
    output logic [NCHAN-1:0]         run,
    output logic [NCHAN-1:0]         done,
    output logic [NCHAN-1:0]         irq_pend,
    output logic [NCHAN-1:0]         ovf,
    output logic                     irq
);

    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
            controller_chan #(
                .BCNTDWN (BCNTDWN),
                .QDEPTH  (QDEPTH)
            ) u_chan (
                .clk       (clk),
                .clr_n     (clr_n),
                .start     (start[gi]),
                .countdown (countdown[gi*BCNTDWN +: BCNTDWN]),
                .step      (step[gi]),
                .irq_ack   (irq_ack[gi]),
`ifdef CONTROLLER_ABORT_EN
                .abort     (abort[gi]),
`endif
                .full      (full[gi]),
                .run       (run[gi]),
                .done      (done[gi]),
                .irq_pend  (irq_pend[gi]),
                .ovf       (ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_pend & irq_mask);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_controller_mc.sv
// ============================================================================
// Module      : tb_controller_mc
// Description : Self-checking bench: queue-level reference model compared every
//               cycle, directed scenarios with literal expectations, random phase.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_controller_mc;

    localparam int NCHAN   = 4;
    localparam int BCNTDWN = 29;
    localparam int QDEPTH  = 2;

    logic                     clk = 1'b0;
    logic                     clr_n = 1'b1;
    logic [NCHAN-1:0]         start = '0;
    logic [NCHAN-1:0]         step = '0;
    logic [NCHAN-1:0]         irq_mask = '0;
    logic [NCHAN-1:0]         irq_ack = '0;
    logic [NCHAN-1:0]         abort = '0;
    logic [NCHAN*BCNTDWN-1:0] countdown = '0;
    logic [NCHAN-1:0]         full, run, done, irq_pend, ovf;
    logic                     irq;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    controller_mc #(
        .NCHAN   (NCHAN),
        .BCNTDWN (BCNTDWN),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .countdown (countdown),
        .step      (step),
        .irq_mask  (irq_mask),
        .irq_ack   (irq_ack),
`ifdef CONTROLLER_ABORT_EN
        .abort     (abort),
`endif
        .full      (full),
        .run       (run),
        .done      (done),
        .irq_pend  (irq_pend),
        .ovf       (ovf),
        .irq       (irq)
    );

    // Reference model: per-channel job list plus remaining-steps count
    int               mq [NCHAN][$];
    int               mrem [NCHAN];
    bit [NCHAN-1:0]   mrun = '0, mdone = '0, mpend = '0, movf = '0;
    bit               mirq = 1'b0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                mq[i].delete();
                mrem[i] = 0;
            end
            mrun = '0; mdone = '0; mpend = '0; movf = '0; mirq = 1'b0;
        end else begin
            mirq = |(mpend & irq_mask);
            for (int i = 0; i < NCHAN; i++) begin
                bit was_full, setp, seto;
                int c;
                was_full = (mq[i].size() == QDEPTH);
                setp = 1'b0;
                seto = 1'b0;
`ifdef CONTROLLER_ABORT_EN
                if (abort[i]) begin
                    mq[i].delete();
                    mrun[i]  = 1'b0;
                    mdone[i] = 1'b0;
                end else
`endif
                begin
                    if (mrun[i]) begin
                        if (step[i]) begin
                            mrem[i]--;
                            if (mrem[i] == 0) begin
                                mrun[i]  = 1'b0;
                                mdone[i] = 1'b1;
                                setp     = 1'b1;
                            end
                        end
                    end else if (mq[i].size() > 0) begin
                        c = mq[i].pop_front();
                        if (c == 0) begin
                            mdone[i] = 1'b1;
                            setp     = 1'b1;
                        end else begin
                            mrun[i]  = 1'b1;
                            mdone[i] = 1'b0;
                            mrem[i]  = c;
                        end
                    end else begin
                        mdone[i] = 1'b0;
                    end
                    if (start[i]) begin
                        if (was_full) seto = 1'b1;
                        else mq[i].push_back(int'(countdown[i*BCNTDWN +: BCNTDWN]));
                    end
                end
                mpend[i] = setp ? 1'b1 : (irq_ack[i] ? 1'b0 : mpend[i]);
                movf[i]  = seto ? 1'b1 : (irq_ack[i] ? 1'b0 : movf[i]);
            end
        end
    end

    task automatic chk_vec(input string nm, input logic [NCHAN-1:0] act, input logic [NCHAN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NCHAN-1:0] mfull;
            for (int i = 0; i < NCHAN; i++) mfull[i] = (mq[i].size() == QDEPTH);
            chk_vec("full", full, mfull);
            chk_vec("run", run, mrun);
            chk_vec("done", done, mdone);
            chk_vec("irq_pend", irq_pend, mpend);
            chk_vec("ovf", ovf, movf);
            chk_vec("irq", {{(NCHAN-1){1'b0}}, irq}, {{(NCHAN-1){1'b0}}, mirq});
        end
    end

    task automatic set_cd(input int ch, input int val);
        countdown[ch*BCNTDWN +: BCNTDWN] = BCNTDWN'(val);
    endtask

    task automatic ack_all();
        irq_ack = '1;
        @(negedge clk);
        irq_ack = '0;
    endtask

    initial begin
        int run_cnt, done_at, irq_at, done_n, d1, d2, others;

        #2 clr_n = 1'b0;
        #1 cmp_en = 1'b1;
        @(negedge clk);
        chk_vec("reset_outs", full | run | done | irq_pend | ovf, '0);
        chk_int("reset_irq", int'(irq), 0);
        clr_n = 1'b1;
        @(negedge clk);

        // Basic task, C=10
        step = '1; irq_mask = 4'b0001; set_cd(0, 10); start[0] = 1'b1;
        @(negedge clk);
        start = '0;
        run_cnt = 0; done_at = -1; irq_at = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (run[0]) run_cnt++;
            if (done[0] && done_at < 0) done_at = k;
            if (irq && irq_at < 0) irq_at = k;
        end
        chk_int("t1_run_width", run_cnt, 10);
        chk_int("t1_done_at", done_at, 11);
        chk_int("t1_irq_at", irq_at, 12);
        irq_ack[0] = 1'b1;
        @(negedge clk);
        irq_ack = '0;
        chk_int("t1_pend_cleared", int'(irq_pend[0]), 0);
        @(negedge clk);
        chk_int("t1_irq_cleared", int'(irq), 0);

        // Zero-length task on ch1
        set_cd(1, 0); start[1] = 1'b1;
        @(negedge clk);
        start = '0;
        run_cnt = 0;
        @(negedge clk);
        chk_int("t2_done", int'(done[1]), 1);
        chk_int("t2_pend", int'(irq_pend[1]), 1);
        for (int k = 0; k < 6; k++) begin
            if (run[1]) run_cnt++;
            @(negedge clk);
        end
        chk_int("t2_no_run", run_cnt, 0);
        ack_all();

        // Queue fill and overflow on ch2
        set_cd(2, 5); start[2] = 1'b1;
        run_cnt = 0; done_n = 0; d1 = -1; d2 = -1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (run[2]) run_cnt++;
            if (done[2]) begin
                done_n++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 2) chk_int("t3_full", int'(full[2]), 1);
            if (k == 3) chk_int("t3_ovf", int'(ovf[2]), 1);
            case (k)
                0: set_cd(2, 3);
                1: set_cd(2, 7);
                2: set_cd(2, 9);
                3: start[2] = 1'b0;
                default: ;
            endcase
        end
        chk_int("t3_run_total", run_cnt, 15);
        chk_int("t3_done_count", done_n, 3);
        chk_int("t3_done1", d1, 6);
        chk_int("t3_done2", d2, 10);
        ack_all();

        // Stalled task, step alternating 1/0 on ch0
        set_cd(0, 20); start[0] = 1'b1;
        run_cnt = 0; done_at = -1; others = 0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (run[0]) run_cnt++;
            if (done[0] && done_at < 0) done_at = k;
            if (|run[NCHAN-1:1]) others++;
            step[0] = (k % 2 == 0);
            if (k == 0) start[0] = 1'b0;
        end
        chk_int("t4_run_width", run_cnt, 40);
        chk_int("t4_done_at", done_at, 41);
        chk_int("t4_others_idle", others, 0);
        step = '1;
        ack_all();

        // Asynchronous reset mid-task
        set_cd(0, 20); set_cd(3, 6); start = 4'b1001;
        @(negedge clk);
        start = '0;
        repeat (5) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk_vec("t5_reset_outs", full | run | done | irq_pend | ovf, '0);
        chk_int("t5_reset_irq", int'(irq), 0);
        @(negedge clk);
        clr_n = 1'b1;
        set_cd(0, 4); start[0] = 1'b1;
        run_cnt = 0; done_at = -1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (run[0]) run_cnt++;
            if (done[0] && done_at < 0) done_at = k;
            if (k == 0) start[0] = 1'b0;
        end
        chk_int("t5_post_run", run_cnt, 4);
        chk_int("t5_post_done", done_at, 5);
        ack_all();

`ifdef CONTROLLER_ABORT_EN
        // Abort a running task with a job queued behind it
        irq_mask = 4'b1000; set_cd(3, 10); start[3] = 1'b1;
        done_n = 0; others = 0;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (done[3]) done_n++;
            if (k >= 4 && run[3]) others++;
            case (k)
                0: set_cd(3, 6);
                1: start[3] = 1'b0;
                3: abort[3] = 1'b1;
                4: abort[3] = 1'b0;
                default: ;
            endcase
        end
        chk_int("t6_no_done", done_n, 0);
        chk_int("t6_no_run_after", others, 0);
        chk_int("t6_no_pend", int'(irq_pend[3]), 0);
        chk_int("t6_no_irq", int'(irq), 0);
        chk_int("t6_flushed", int'(full[3]), 0);
`endif

        // Randomized traffic; the model checks every cycle
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NCHAN; i++) begin
                start[i]   = ($urandom_range(0, 3) == 0);
                step[i]    = ($urandom_range(0, 3) != 0);
                irq_ack[i] = ($urandom_range(0, 7) == 0);
                set_cd(i, int'($urandom_range(0, 6)));
`ifdef CONTROLLER_ABORT_EN
                abort[i]   = ($urandom_range(0, 31) == 0);
`endif
            end
            if ($urandom_range(0, 15) == 0) irq_mask = NCHAN'($urandom);
            @(negedge clk);
        end
        start = '0; abort = '0; irq_ack = '0; step = '1;
        repeat (40) @(negedge clk);
        chk_vec("drain_idle", run | done, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
